peripheral_arbiter: RTL and testbench
=====================================

// Module: peripheral_arbiter
// PURPOSE
//  Shares one peripheral bus slave port (e.g. the peripheral multiplexer's master side) between N bus
//  masters (CPU, DMA, debug). Round-robin grant, held for one full transaction; the winner's
//  request/address/data pass through to the slave. A watchdog aborts transactions the slave never acknowledges.
// PARAMETERS
//  MASTER_COUNT   2    number of requesting masters (>=2)
//  ADDR_WIDTH     16   peripheral address width
//  TIMEOUT        255  cycles in BUSY without ready before abort (>=1)
// PORTS
//  clk              in   1               system clock, rising edge
//  reset            in   1               asynchronous, active-high
//  m_address        in   MC*ADDR_WIDTH   per-master address, master i at [i*AW +: AW]
//  m_data_write     in   MC*8            per-master write data
//  m_read_request   in   MC              per-master read request, level, held until ready
//  m_write_request  in   MC              per-master write request, level, held until ready
//  m_data_read      out  8               read data, broadcast to all masters
//  m_read_ready     out  MC              read completion pulse to granted master only
//  m_write_ready    out  MC              write completion pulse to granted master only
//  s_address        out  ADDR_WIDTH      to slave
//  s_data_write     out  8               to slave
//  s_read_request   out  1               to slave
//  s_write_request  out  1               to slave
//  s_data_read      in   8               from slave
//  s_read_ready     in   1               from slave, 1-cycle pulse
//  s_write_ready    in   1               from slave, 1-cycle pulse
//  grant            out  MC              one-hot current owner, 0 when IDLE
//  timeout_error    out  1               1-cycle pulse when a transaction is aborted
// BEHAVIOUR
//  - Reset: state=IDLE, grant=0, rr pointer=0, watchdog=0; all s_* requests 0, s_address/s_data_write 0,
//    all m_*_ready 0, m_data_read 0, timeout_error 0. Async assert, synchronous-release expected upstream.
//  - Master i "requests" if m_read_request[i] | m_write_request[i]. Both set: treated as write
//    (s_read_request forced 0).
//  - IDLE: if any request, pick first requester at or after rr pointer (wrapping modulo MC), register
//    grant, go BUSY. Arbitration latency 1 cycle: request at cycle t -> s_*_request high at t+1.
//  - BUSY: s_address, s_data_write, s_*_request combinationally follow the granted master; other masters
//    see ready=0. m_data_read = s_data_read while BUSY, else 0.
//  - Completion: s_read_ready or s_write_ready in BUSY -> same-cycle pulse on granted master's matching
//    ready; next cycle state=IDLE, grant=0, rr pointer=granted+1 (wraps MC-1 -> 0). Mandatory IDLE cycle
//    between transactions, so a master must drop its request the cycle after its ready.
//  - Ready of wrong type (e.g. write_ready during a read) is still forwarded and ends the transaction.
//  - Ready while IDLE: ignored, not forwarded.
//  - Granted master drops request before ready: transaction abandoned, next cycle IDLE, pointer advances.
//  - Watchdog: counts cycles in BUSY, cleared on entering BUSY; at count==TIMEOUT without ready: pulse
//    matching m_*_ready to owner with m_data_read=8'hFF, pulse timeout_error, go IDLE, pointer advances.
//    Ready on the TIMEOUT cycle wins: normal completion, no error.
//  - Watchdog width $clog2(TIMEOUT+1); no saturation needed since BUSY always exits.
//  - Reset mid-transaction: slave requests drop immediately (async); slave must tolerate abandonment.
// STRUCTURE
//  - peripheral_bus_pkg: arb_state_t {ARB_IDLE, ARB_BUSY}; PERIPH_DATA_WIDTH=8; READ_TIMEOUT_DATA=8'hFF.
//  - Sub-module rr_priority_picker #(N): comb; inputs req[N], ptr; outputs one-hot gnt, index, any.
//  - Top: state/grant/pointer/watchdog regs + output muxing by granted index.
// TESTING
//  1 Reset during BUSY (MC=2) -> all outputs 0 same cycle; after release, first request granted to m0.
//  2 Single master: m1 write addr 16'h0040 data 8'hA5 -> s_write_request at t+1 with those values;
//    s_write_ready -> m_write_ready=2'b10 same cycle; grant=0 next cycle.
//  3 m0,m1 read continuously, slave ready 2 cycles after request -> grants alternate m0,m1,m0,...;
//    m_data_read equals s_data_read only on owner's ready.
//  4 MC=3, ptr=2, m0+m2 request -> m2 granted; then m0 requests -> m0 granted (wrap).
//  5 TIMEOUT=4, slave silent -> after 4 BUSY cycles m_read_ready to owner, data 8'hFF, timeout_error 1 cycle.
//  6 Owner drops request mid-BUSY; stray s_read_ready in IDLE -> no ready forwarded, no error, IDLE.

Source files
------------

// File: rtl/peripheral_bus_pkg.sv
// Shared types and constants for the peripheral bus arbiter.
package peripheral_bus_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam int PERIPH_DATA_WIDTH = 8;
  localparam logic [PERIPH_DATA_WIDTH-1:0] READ_TIMEOUT_DATA = 8'hFF;

  // Index width for n items; never zero so single-bit selects stay legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping modulo N.
module rr_priority_picker
  import peripheral_bus_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] index,
  output logic          any
);

  always_comb begin
    int j;
    j     = 0;
    gnt   = '0;
    index = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        index  = IW'(j);
      end
    end
  end

endmodule

// File: rtl/peripheral_arbiter.sv
// Round-robin arbiter sharing one peripheral slave port among MASTER_COUNT masters,
// with a watchdog that aborts transactions the slave never acknowledges.
//   state    | meaning
//   ARB_IDLE | no owner; next edge grants first requester at/after ptr
//   ARB_BUSY | grant held; owner routed to slave, watchdog counting
module peripheral_arbiter
  import peripheral_bus_pkg::*;
#(
  parameter int MASTER_COUNT = 2,
  parameter int ADDR_WIDTH   = 16,
  parameter int TIMEOUT      = 255
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [MASTER_COUNT*ADDR_WIDTH-1:0]       m_address,
  input  logic [MASTER_COUNT*PERIPH_DATA_WIDTH-1:0] m_data_write,
  input  logic [MASTER_COUNT-1:0]                  m_read_request,
  input  logic [MASTER_COUNT-1:0]                  m_write_request,
  output logic [PERIPH_DATA_WIDTH-1:0]             m_data_read,
  output logic [MASTER_COUNT-1:0]                  m_read_ready,
  output logic [MASTER_COUNT-1:0]                  m_write_ready,
  output logic [ADDR_WIDTH-1:0]                    s_address,
  output logic [PERIPH_DATA_WIDTH-1:0]             s_data_write,
  output logic                                     s_read_request,
  output logic                                     s_write_request,
  input  logic [PERIPH_DATA_WIDTH-1:0]             s_data_read,
  input  logic                                     s_read_ready,
  input  logic                                     s_write_ready,
  output logic [MASTER_COUNT-1:0]                  grant,
  output logic                                     timeout_error
);

  localparam int MC = MASTER_COUNT;
  localparam int DW = PERIPH_DATA_WIDTH;
  localparam int IW = idx_width(MC);
  localparam int WW = $clog2(TIMEOUT + 1);

  arb_state_t      state;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   ptr;
  logic [WW-1:0]   wdog;

  logic [MC-1:0]   req;
  logic [MC-1:0]   pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

  logic            busy;
  logic            own_rd;
  logic            own_wr;
  logic            own_req;
  logic            slave_done;
  logic            abandon;
  logic            expire;
  logic            end_xact;
  logic [IW-1:0]   next_ptr;

  assign req = m_read_request | m_write_request;

  rr_priority_picker #(.N(MC)) u_picker (
    .req   (req),
    .ptr   (ptr),
    .gnt   (pick_gnt),
    .index (pick_idx),
    .any   (pick_any)
  );

  assign busy    = (state == ARB_BUSY);
  assign own_rd  = m_read_request[owner];
  assign own_wr  = m_write_request[owner];
  assign own_req = own_rd | own_wr;

  // Priority when several end conditions coincide: slave ready, then abandonment, then watchdog.
  assign slave_done = busy & (s_read_ready | s_write_ready);
  assign abandon    = busy & ~slave_done & ~own_req;
  assign expire     = busy & ~slave_done & own_req & (wdog == WW'(TIMEOUT));
  assign end_xact   = slave_done | abandon | expire;
  assign next_ptr   = (owner == IW'(MC - 1)) ? '0 : owner + 1'b1;

  always_comb begin
    s_address       = '0;
    s_data_write    = '0;
    s_read_request  = 1'b0;
    s_write_request = 1'b0;
    m_read_ready    = '0;
    m_write_ready   = '0;
    m_data_read     = '0;
    timeout_error   = 1'b0;
    if (busy) begin
      s_address       = m_address[int'(owner)*ADDR_WIDTH +: ADDR_WIDTH];
      s_data_write    = m_data_write[int'(owner)*DW +: DW];
      s_write_request = own_wr;
      s_read_request  = own_rd & ~own_wr;
      m_data_read     = s_data_read;
      if (slave_done) begin
        m_read_ready[owner]  = s_read_ready;
        m_write_ready[owner] = s_write_ready;
      end else if (expire) begin
        m_data_read   = READ_TIMEOUT_DATA;
        timeout_error = 1'b1;
        if (own_wr) m_write_ready[owner] = 1'b1;
        else        m_read_ready[owner]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ARB_IDLE;
      grant <= '0;
      owner <= '0;
      ptr   <= '0;
      wdog  <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            state <= ARB_BUSY;
            grant <= pick_gnt;
            owner <= pick_idx;
            wdog  <= '0;
          end
        end
        ARB_BUSY: begin
          if (end_xact) begin
            state <= ARB_IDLE;
            grant <= '0;
            ptr   <= next_ptr;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_arbiter.sv
// Scoreboard bench for peripheral_arbiter: 3 masters, TIMEOUT=4, directed transactions.
module tb_peripheral_arbiter;

  localparam int MC = 3;
  localparam int AW = 16;
  localparam int TO = 4;

  logic            clk;
  logic            reset;
  logic [MC*AW-1:0] m_address;
  logic [MC*8-1:0] m_data_write;
  logic [MC-1:0]   m_read_request;
  logic [MC-1:0]   m_write_request;
  logic [7:0]      m_data_read;
  logic [MC-1:0]   m_read_ready;
  logic [MC-1:0]   m_write_ready;
  logic [AW-1:0]   s_address;
  logic [7:0]      s_data_write;
  logic            s_read_request;
  logic            s_write_request;
  logic [7:0]      s_data_read;
  logic            s_read_ready;
  logic            s_write_ready;
  logic [MC-1:0]   grant;
  logic            timeout_error;

  peripheral_arbiter #(.MASTER_COUNT(MC), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk             (clk),
    .reset           (reset),
    .m_address       (m_address),
    .m_data_write    (m_data_write),
    .m_read_request  (m_read_request),
    .m_write_request (m_write_request),
    .m_data_read     (m_data_read),
    .m_read_ready    (m_read_ready),
    .m_write_ready   (m_write_ready),
    .s_address       (s_address),
    .s_data_write    (s_data_write),
    .s_read_request  (s_read_request),
    .s_write_request (s_write_request),
    .s_data_read     (s_data_read),
    .s_read_ready    (s_read_ready),
    .s_write_ready   (s_write_ready),
    .grant           (grant),
    .timeout_error   (timeout_error)
  );

  typedef struct {
    logic [MC-1:0] rr;
    logic [MC-1:0] wr;
    logic [7:0]    data;
    logic          terr;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          errors = 0;
  int          checks = 0;
  logic [MC-1:0] rearm_rd = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL sim_timeout: bench did not finish, required finish before 200000");
    $fatal(1, "bench time limit");
  end

  // Monitor: every completion pulse on the master side must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && (m_read_ready != '0 || m_write_ready != '0 || timeout_error)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ready: got rr=%b wr=%b data=%h terr=%b, required no pulse",
                 m_read_ready, m_write_ready, m_data_read, timeout_error);
      end else begin
        e = q.pop_front();
        if (m_read_ready !== e.rr || m_write_ready !== e.wr ||
            m_data_read !== e.data || timeout_error !== e.terr) begin
          errors++;
          $display("FAIL scoreboard: got rr=%b wr=%b data=%h terr=%b, required rr=%b wr=%b data=%h terr=%b",
                   m_read_ready, m_write_ready, m_data_read, timeout_error,
                   e.rr, e.wr, e.data, e.terr);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [MC-1:0] rr, input logic [MC-1:0] wr,
                      input logic [7:0] data, input logic terr);
    exp_t x;
    x.rr = rr; x.wr = wr; x.data = data; x.terr = terr;
    q.push_back(x);
  endtask

  // Starts from IDLE: master m requests, is expected to win, slave answers after busy_cycles extra cycles.
  task automatic run_xact(input int m, input bit wr, input logic [15:0] addr,
                          input logic [7:0] wd, input logic [7:0] rd,
                          input int busy_cycles, input bit wrong_type);
    logic [MC-1:0] oh;
    oh = MC'(1 << m);
    m_address[m*AW +: AW] = addr;
    m_data_write[m*8 +: 8] = wd;
    if (wr) m_write_request[m] = 1'b1;
    else    m_read_request[m]  = 1'b1;
    tick();
    chk("grant", 32'(grant), 32'(oh));
    chk("s_address", 32'(s_address), 32'(addr));
    chk("s_data_write", 32'(s_data_write), 32'(wd));
    chk("s_requests", 32'({s_write_request, s_read_request}), wr ? 32'h2 : 32'h1);
    m_read_request = m_read_request | rearm_rd;
    repeat (busy_cycles) tick();
    s_data_read = rd;
    if (wr ^ wrong_type) begin
      push('0, oh, rd, 1'b0);
      s_write_ready = 1'b1;
    end else begin
      push(oh, '0, rd, 1'b0);
      s_read_ready = 1'b1;
    end
    tick();
    s_read_ready  = 1'b0;
    s_write_ready = 1'b0;
    m_read_request[m]  = 1'b0;
    m_write_request[m] = 1'b0;
    chk("grant_after", 32'(grant), 32'h0);
    chk("data_idle", 32'(m_data_read), 32'h0);
  endtask

  initial begin
    reset           = 1'b1;
    m_address       = '0;
    m_data_write    = '0;
    m_read_request  = '0;
    m_write_request = '0;
    s_data_read     = '0;
    s_read_ready    = 1'b0;
    s_write_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_s_req", 32'({s_write_request, s_read_request}), 32'h0);
    chk("rst_s_address", 32'(s_address), 32'h0);
    chk("rst_ready", 32'({m_read_ready, m_write_ready, timeout_error}), 32'h0);
    reset = 1'b0;

    // single master write: m1, ptr 0 -> 2
    run_xact(1, 1'b1, 16'h0040, 8'hA5, 8'h21, 1, 1'b0);

    // read+write both set is a write: m0 wins by wrapping from ptr 2, ptr -> 1
    m_read_request[0] = 1'b1;
    run_xact(0, 1'b1, 16'h0100, 8'h3C, 8'h11, 1, 1'b0);

    // reset during BUSY, then pointer must be back at 0
    m_address[1*AW +: AW] = 16'h0300;
    m_read_request[1] = 1'b1;
    tick();
    chk("pre_rst_grant", 32'(grant), 32'h2);
    chk("pre_rst_s_read", 32'(s_read_request), 32'h1);
    s_data_read = 8'h99;
    reset = 1'b1;
    #1;
    chk("async_rst_s_read", 32'(s_read_request), 32'h0);
    chk("async_rst_grant", 32'(grant), 32'h0);
    chk("async_rst_data", 32'(m_data_read), 32'h0);
    chk("async_rst_addr", 32'(s_address), 32'h0);
    m_read_request = 3'b011;
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_xact(0, 1'b0, 16'h0010, 8'h00, 8'h42, 1, 1'b0);
    m_read_request = '0;

    // continuous reads by m0 and m1 alternate, starting from ptr 1
    m_address[0*AW +: AW] = 16'h0A00;
    m_address[1*AW +: AW] = 16'h0B01;
    m_read_request = 3'b011;
    rearm_rd = 3'b011;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) run_xact(1, 1'b0, 16'h0B01, 8'h00, 8'(8'h10 + k), 1, 1'b0);
      else            run_xact(0, 1'b0, 16'h0A00, 8'h00, 8'(8'h10 + k), 1, 1'b0);
    end
    m_read_request = '0;
    rearm_rd = '0;

    // write-ready during a read still completes it, forwarded as write ready; ptr 1 -> 2
    run_xact(1, 1'b0, 16'h0200, 8'h00, 8'hC3, 1, 1'b1);

    // ptr 2 with m0+m2: m2 wins; then ptr wraps to 0 so m0 beats m1
    m_read_request = 3'b101;
    run_xact(2, 1'b0, 16'h0222, 8'h00, 8'h5E, 1, 1'b0);
    m_read_request = '0;
    m_read_request = 3'b011;
    run_xact(0, 1'b0, 16'h0333, 8'h00, 8'h6F, 1, 1'b0);
    m_read_request = '0;

    // watchdog: m1 read, silent slave, abort when count reaches TIMEOUT
    m_address[1*AW +: AW] = 16'h0444;
    m_read_request[1] = 1'b1;
    s_data_read = 8'h5A;
    tick();
    chk("to_grant", 32'(grant), 32'h2);
    repeat (TO) tick();
    push(3'b010, 3'b000, 8'hFF, 1'b1);
    tick();
    m_read_request = '0;
    chk("to_grant_after", 32'(grant), 32'h0);

    // ready exactly on the TIMEOUT cycle wins; m2 write chosen over m1 from ptr 2
    m_read_request[1] = 1'b1;
    run_xact(2, 1'b1, 16'h0555, 8'h7E, 8'h3B, TO, 1'b0);
    m_read_request = '0;

    // owner abandons mid-BUSY, stray ready in IDLE is ignored; ptr 0 -> 1
    m_address[0*AW +: AW] = 16'h0666;
    m_read_request[0] = 1'b1;
    tick();
    chk("ab_grant", 32'(grant), 32'h1);
    tick();
    m_read_request[0] = 1'b0;
    #1;
    chk("ab_s_read", 32'(s_read_request), 32'h0);
    tick();
    chk("ab_grant_after", 32'(grant), 32'h0);
    s_data_read  = 8'h77;
    s_read_ready = 1'b1;
    #1;
    chk("stray_ready", 32'({m_read_ready, m_write_ready}), 32'h0);
    chk("stray_terr", 32'(timeout_error), 32'h0);
    chk("stray_data", 32'(m_data_read), 32'h0);
    tick();
    s_read_ready = 1'b0;
    chk("stray_grant", 32'(grant), 32'h0);
    m_read_request = 3'b011;
    run_xact(1, 1'b0, 16'h0777, 8'h00, 8'h88, 1, 1'b0);
    m_read_request = '0;

    repeat (3) tick();
    chk("queue_empty", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
